// File: rtl/control_smoother.sv
// Brings ADC_SPI_In parameter frames into the fpga_clock domain. The frequency
// glides toward the clamped target once per output sample; scale changes wait for a sample boundary.
module control_smoother #(
  parameter int          DIV_BIT    = 8,
  parameter int          SLEW_SHIFT = 4,
  parameter logic [15:0] FREQ_MIN   = 16'd16,
  parameter logic [15:0] FREQ_MAX   = 16'd24000,
  parameter logic [15:0] RESET_FREQ = 16'd1000
) (
  input  logic               fpga_clock,
  input  logic               reset,
  input  logic [15:0]        i_data0,
  input  logic [15:0]        i_data1,
  input  logic               i_data_received,
  input  logic               i_sample_tick,
  output logic [15:0]        o_frequency,
  output logic [DIV_BIT-1:0] o_harmonic_scale,
  output logic [DIV_BIT-1:0] o_scale_initial,
  output logic               o_update,
  output logic               o_overrun,
  output logic [1:0]         o_cap_state,
  output logic [1:0]         o_gl_state
);

  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_LATCH = 2'd1,
    CAP_CLAMP = 2'd2
  } cap_state_t;

  typedef enum logic [1:0] {
    GL_IDLE  = 2'd0,
    GL_CALC  = 2'd1,
    GL_APPLY = 2'd2
  } gl_state_t;

  cap_state_t         cap_state;
  gl_state_t          gl_state;

  logic               strobe_sync1;
  logic               strobe_sync2;
  logic               strobe_hist;
  logic               frame_event;

  logic [15:0]        shadow0;
  logic [15:0]        shadow1;
  logic [15:0]        target;
  logic [15:0]        clamped;
  logic [DIV_BIT-1:0] pend_scale;
  logic [DIV_BIT-1:0] pend_initial;
  logic               pending;
  logic               pend_set;
  logic               pend_clr;

  logic [16:0]        diff;
  logic [16:0]        mag;
  logic [16:0]        calc_diff;
  logic [16:0]        calc_abs;
  logic [16:0]        calc_mag;
  logic [16:0]        step_sum;

  assign o_cap_state = cap_state;
  assign o_gl_state  = gl_state;

  // The strobe is an asynchronous level of arbitrary width; only its rising edge counts.
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      strobe_sync1 <= 1'b0;
      strobe_sync2 <= 1'b0;
      strobe_hist  <= 1'b0;
    end else begin
      strobe_sync1 <= i_data_received;
      strobe_sync2 <= strobe_sync1;
      strobe_hist  <= strobe_sync2;
    end
  end

  assign frame_event = strobe_sync2 & ~strobe_hist;

  always_comb begin
    clamped = shadow0;
    if (shadow0 < FREQ_MIN) begin
      clamped = FREQ_MIN;
    end else if (shadow0 > FREQ_MAX) begin
      clamped = FREQ_MAX;
    end
  end

  // Capture FSM: the data words are sampled one cycle after the synchronised edge.
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      cap_state    <= CAP_IDLE;
      shadow0      <= 16'd0;
      shadow1      <= 16'd0;
      target       <= RESET_FREQ;
      pend_scale   <= '0;
      pend_initial <= '1;
    end else begin
      case (cap_state)
        CAP_IDLE: begin
          if (frame_event) begin
            cap_state <= CAP_LATCH;
          end
        end
        CAP_LATCH: begin
          shadow0   <= i_data0;
          shadow1   <= i_data1;
          cap_state <= CAP_CLAMP;
        end
        CAP_CLAMP: begin
          target       <= clamped;
          pend_scale   <= shadow1[DIV_BIT-1:0];
          pend_initial <= shadow1[DIV_BIT +: DIV_BIT];
          cap_state    <= CAP_IDLE;
        end
        default: cap_state <= CAP_IDLE;
      endcase
    end
  end

  assign pend_set = (cap_state == CAP_CLAMP);
  assign pend_clr = (gl_state == GL_APPLY);

  // A new frame landing on the same edge as the apply stays pending and is not an overrun.
  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      pending   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (pend_set) begin
        pending <= 1'b1;
        if (pending && !pend_clr) begin
          o_overrun <= 1'b1;
        end
      end else if (pend_clr) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    calc_diff = {1'b0, target} - {1'b0, o_frequency};
    calc_abs  = calc_diff[16] ? (17'd0 - calc_diff) : calc_diff;
    calc_mag  = calc_abs >> SLEW_SHIFT;
    if ((calc_mag == 17'd0) && (calc_diff != 17'd0)) begin
      calc_mag = 17'd1;
    end
  end

  // mag never exceeds |diff|, so the step cannot cross the target.
  assign step_sum = diff[16] ? ({1'b0, o_frequency} - mag) : ({1'b0, o_frequency} + mag);

  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      gl_state         <= GL_IDLE;
      diff             <= 17'd0;
      mag              <= 17'd0;
      o_frequency      <= RESET_FREQ;
      o_harmonic_scale <= '0;
      o_scale_initial  <= '1;
      o_update         <= 1'b0;
    end else begin
      o_update <= 1'b0;
      case (gl_state)
        GL_IDLE: begin
          if (i_sample_tick) begin
            gl_state <= GL_CALC;
          end
        end
        GL_CALC: begin
          diff     <= calc_diff;
          mag      <= calc_mag;
          gl_state <= GL_APPLY;
        end
        GL_APPLY: begin
          if (diff != 17'd0) begin
            o_frequency <= 16'(step_sum);
          end
          if (pending) begin
            o_harmonic_scale <= pend_scale;
            o_scale_initial  <= pend_initial;
          end
          o_update <= 1'b1;
          gl_state <= GL_IDLE;
        end
        default: gl_state <= GL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_smoother.sv
// Directed bench for control_smoother: one instance with the default glide and
// one with SLEW_SHIFT=0, both driven from the same stimulus.
module tb_control_smoother;

  logic        fpga_clock = 1'b0;
  logic        reset;
  logic [15:0] data0;
  logic [15:0] data1;
  logic        strobe;
  logic        tick;

  logic [15:0] a_freq;
  logic [7:0]  a_hs;
  logic [7:0]  a_si;
  logic        a_upd;
  logic        a_ovr;
  logic [1:0]  a_cap;
  logic [1:0]  a_gl;

  logic [15:0] b_freq;
  logic [7:0]  b_hs;
  logic [7:0]  b_si;
  logic        b_upd;
  logic        b_ovr;
  logic [1:0]  b_cap;
  logic [1:0]  b_gl;

  int total = 0;
  int bad   = 0;

  always #5 fpga_clock = ~fpga_clock;

  control_smoother dut (
    .fpga_clock(fpga_clock), .reset(reset),
    .i_data0(data0), .i_data1(data1),
    .i_data_received(strobe), .i_sample_tick(tick),
    .o_frequency(a_freq), .o_harmonic_scale(a_hs), .o_scale_initial(a_si),
    .o_update(a_upd), .o_overrun(a_ovr),
    .o_cap_state(a_cap), .o_gl_state(a_gl)
  );

  control_smoother #(.SLEW_SHIFT(0)) dut0 (
    .fpga_clock(fpga_clock), .reset(reset),
    .i_data0(data0), .i_data1(data1),
    .i_data_received(strobe), .i_sample_tick(tick),
    .o_frequency(b_freq), .o_harmonic_scale(b_hs), .o_scale_initial(b_si),
    .o_update(b_upd), .o_overrun(b_ovr),
    .o_cap_state(b_cap), .o_gl_state(b_gl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Inputs are always driven 1 ns after a rising edge; outputs are read there too.
  task automatic step(input int n);
    repeat (n) @(posedge fpga_clock);
    #1;
  endtask

  task automatic do_reset();
    strobe = 1'b0;
    tick   = 1'b0;
    reset  = 1'b1;
    step(2);
    reset  = 1'b0;
    step(1);
  endtask

  task automatic frame(input logic [15:0] d0, input logic [15:0] d1, input int width);
    data0  = d0;
    data1  = d1;
    strobe = 1'b1;
    step(width);
    strobe = 1'b0;
    step(6);
  endtask

  // Returns just after the edge at which the glide result is written.
  task automatic tick_wait();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
  endtask

  initial begin
    logic [15:0] exp_f;
    int          d;
    int          m;

    reset = 1'b1;
    data0 = 16'd0;
    data1 = 16'd0;
    strobe = 1'b0;
    tick = 1'b0;
    do_reset();

    check("rst_freq", 32'(a_freq), 32'd1000);
    check("rst_hs", 32'(a_hs), 32'd0);
    check("rst_si", 32'(a_si), 32'd255);
    check("rst_upd", 32'(a_upd), 32'd0);
    check("rst_ovr", 32'(a_ovr), 32'd0);

    // Glide 1000 -> 2000 with a wide strobe that must count as one frame.
    frame(16'd2000, 16'hFF00, 5);
    check("wide_strobe_ovr", 32'(a_ovr), 32'd0);
    tick_wait();
    check("glide_1", 32'(a_freq), 32'd1062);
    check("glide_1_upd", 32'(a_upd), 32'd1);
    tick_wait();
    check("glide_2", 32'(a_freq), 32'd1120);
    tick_wait();
    check("glide_3", 32'(a_freq), 32'd1175);
    exp_f = 16'd1175;
    for (int i = 0; i < 200 && exp_f != 16'd2000; i++) begin
      d = 2000 - int'(exp_f);
      m = (d < 0 ? -d : d) >>> 4;
      if (m == 0 && d != 0) m = 1;
      exp_f = (d < 0) ? exp_f - 16'(m) : exp_f + 16'(m);
      tick_wait();
      check("glide_step", 32'(a_freq), 32'(exp_f));
    end
    check("glide_final", 32'(a_freq), 32'd2000);
    tick_wait();
    check("glide_hold", 32'(a_freq), 32'd2000);
    check("glide_ovr", 32'(a_ovr), 32'd0);

    // Minimum step of one.
    do_reset();
    frame(16'd1005, 16'hFF00, 1);
    for (int i = 1; i <= 7; i++) begin
      tick_wait();
      check("minstep_freq", 32'(a_freq), (i <= 5) ? 32'(1000 + i) : 32'd1005);
      check("minstep_upd", 32'(a_upd), 32'd1);
    end

    // Clamping, seen directly on the SLEW_SHIFT=0 instance.
    do_reset();
    frame(16'd0, 16'hFF00, 2);
    tick_wait();
    check("clamp_lo", 32'(b_freq), 32'd16);
    check("clamp_lo_glide", 32'(a_freq), 32'd939);
    frame(16'hFFFF, 16'hFF00, 2);
    tick_wait();
    check("clamp_hi", 32'(b_freq), 32'd24000);
    check("clamp_hi_glide", 32'(a_freq), 32'd2380);
    frame(16'd500, 16'hFF00, 1);
    tick_wait();
    check("clamp_pass", 32'(b_freq), 32'd500);

    // Scale change lands exactly with the o_update pulse.
    do_reset();
    frame(16'd1000, 16'hC810, 1);
    check("scale_wait_si", 32'(a_si), 32'd255);
    check("scale_wait_hs", 32'(a_hs), 32'd0);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    check("scale_pre_si", 32'(a_si), 32'd255);
    check("scale_pre_hs", 32'(a_hs), 32'd0);
    check("scale_pre_upd", 32'(a_upd), 32'd0);
    step(1);
    check("scale_si", 32'(a_si), 32'hC8);
    check("scale_hs", 32'(a_hs), 32'h10);
    check("scale_upd", 32'(a_upd), 32'd1);
    check("scale_freq", 32'(a_freq), 32'd1000);
    step(1);
    check("scale_upd_end", 32'(a_upd), 32'd0);
    check("scale_hold_si", 32'(a_si), 32'hC8);

    // Two frames before one tick: overrun, newest frame wins.
    do_reset();
    frame(16'd1000, 16'h1122, 1);
    check("ovr_first", 32'(a_ovr), 32'd0);
    frame(16'd1000, 16'h3344, 1);
    check("ovr_second", 32'(a_ovr), 32'd1);
    tick_wait();
    check("ovr_si", 32'(a_si), 32'h33);
    check("ovr_hs", 32'(a_hs), 32'h44);

    // Second frame's CAP_CLAMP lands on the same edge as GL_APPLY.
    do_reset();
    frame(16'd1000, 16'h1122, 1);
    data1  = 16'h3344;
    strobe = 1'b1;
    step(1);
    strobe = 1'b0;
    step(1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
    check("coin_si", 32'(a_si), 32'h11);
    check("coin_hs", 32'(a_hs), 32'h22);
    check("coin_ovr", 32'(a_ovr), 32'd0);
    step(3);
    tick_wait();
    check("coin_next_si", 32'(a_si), 32'h33);
    check("coin_next_hs", 32'(a_hs), 32'h44);
    check("coin_next_ovr", 32'(a_ovr), 32'd0);

    // Reset during GL_CALC on the instant-jump instance.
    do_reset();
    frame(16'd1500, 16'h1122, 1);
    tick_wait();
    check("mid_pre_freq", 32'(b_freq), 32'd1500);
    check("mid_pre_hs", 32'(b_hs), 32'h22);
    frame(16'd3000, 16'h5566, 1);
    frame(16'd3000, 16'h5566, 1);
    check("mid_pre_ovr", 32'(b_ovr), 32'd1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    reset = 1'b1;
    step(1);
    check("mid_rst_freq", 32'(b_freq), 32'd1000);
    check("mid_rst_hs", 32'(b_hs), 32'd0);
    check("mid_rst_si", 32'(b_si), 32'd255);
    check("mid_rst_upd", 32'(b_upd), 32'd0);
    check("mid_rst_ovr", 32'(b_ovr), 32'd0);
    reset = 1'b0;
    step(2);
    tick_wait();
    check("post_rst_freq", 32'(b_freq), 32'd1000);
    check("post_rst_hs", 32'(b_hs), 32'd0);
    check("post_rst_si", 32'(b_si), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
